// File: rtl/mc_mem_port.sv
// -----------------------------------------------------------------------------
// mc_mem_port
// Load/store unit that sits between the multicycle control FSM and the unified
// instruction/data memory. It accepts one request at a time and waits on the
// memory mem_rdy handshake. It generates byte enables and lane-shifted store
// data, sign- or zero-extends load data, and flags misaligned accesses.
//
// Optional feature: define MC_MEM_TIMEOUT_EN to bound the mem_rdy wait to
// TIMEOUT cycles. On expiry the unit reports an error and parks in a dead
// state with halt=1 until reset. Without the macro, ACCESS waits indefinitely
// and halt is tied to 0.
//
// Parameters
//   XLEN     data width (32 or 64), NB = XLEN/8 bytes per word
//   ADDR_W   byte address width
//   TIMEOUT  max mem_rdy wait cycles (only with MC_MEM_TIMEOUT_EN), >= 1
//
// Ports
//   clk, sys_rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake with the control FSM
//   req_we/req_size/req_unsigned/req_addr/req_wdata  request fields
//   rsp_valid/rsp_err/rsp_rdata one-cycle response, extended load data
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata         memory request side
//   mem_rdy/mem_rdata           memory completion and read data
//   halt                        sticky fatal error (timeout)
// -----------------------------------------------------------------------------
module mc_mem_port #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   sys_rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [XLEN-1:0]        req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [XLEN-1:0]        rsp_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [XLEN/8-1:0]      mem_be,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic                   mem_rdy,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   halt
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR,
    DEAD
  } state_e;

  state_e            state_q;

  // Latched request fields needed after the accept edge
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;

  // Registered outputs
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [NB-1:0]     mem_be_q;
  logic [XLEN-1:0]   mem_wdata_q;

`ifdef MC_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q;
  logic              dead_q;   // ERR entered from a timeout: continue to DEAD
  logic              halt_q;
`endif

  // Combinational request decode and load extension
  logic [OFF_W-1:0]  off_d;
  logic [ADDR_W-1:0] addr_d;
  logic              misalign_d;
  logic [NB-1:0]     be_d;
  logic [XLEN-1:0]   wdata_d;
  logic [XLEN-1:0]   shifted_d;
  logic [XLEN-1:0]   rdata_d;
  int unsigned       nbits_d;
  logic [IDX_W-1:0]  sign_idx_d;

  function automatic int unsigned size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return NB;
    endcase
  endfunction

  always_comb begin
    off_d  = req_addr[OFF_W-1:0];
    addr_d = req_addr;
    addr_d[OFF_W-1:0] = '0;

    case (req_size)
      2'b00:   misalign_d = 1'b0;
      2'b01:   misalign_d = req_addr[0];
      2'b10:   misalign_d = |req_addr[1:0];
      default: misalign_d = (XLEN != 64) || (|req_addr[2:0]);
    endcase

    be_d = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be_d[i] = (i < size_bytes(req_size));
    end
    be_d    = be_d << off_d;
    wdata_d = req_wdata << {off_d, 3'b000};

    // Load path works on latched fields; mem_rdata is valid in ACCESS only
    shifted_d  = mem_rdata >> {off_q, 3'b000};
    nbits_d    = 8 * size_bytes(size_q);
    sign_idx_d = IDX_W'(nbits_d - 1);
    rdata_d    = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      rdata_d[i] = (i < nbits_d) ? shifted_d[i] : (~uns_q & shifted_d[sign_idx_d]);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
`ifdef MC_MEM_TIMEOUT_EN
      cnt_q       <= '0;
      dead_q      <= 1'b0;
      halt_q      <= 1'b0;
`endif
    end else begin
      // Response strobes are single-cycle pulses
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            off_q       <= off_d;
            req_ready_q <= 1'b0;
            if (misalign_d) begin
              state_q     <= ERR;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= addr_d;
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
`ifdef MC_MEM_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end
          end
        end

        ACCESS: begin
          // mem_rdy wins over an expiring count on the same edge
          if (mem_rdy) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? '0 : rdata_d;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
          end
`ifdef MC_MEM_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q     <= ERR;
            dead_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end

        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_rdata_q <= '0;
        end

        ERR: begin
`ifdef MC_MEM_TIMEOUT_EN
          if (dead_q) begin
            state_q <= DEAD;
            halt_q  <= 1'b1;
          end else
`endif
          begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end
        end

        DEAD: state_q <= DEAD;

        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
`ifdef MC_MEM_TIMEOUT_EN
  assign halt      = halt_q;
`else
  assign halt      = 1'b0;
`endif

endmodule

// File: tb/tb_mc_mem_port.sv
// -----------------------------------------------------------------------------
// tb_mc_mem_port
// Self-checking bench for mc_mem_port (XLEN=32, TIMEOUT=4). Expected responses
// are queued when a request is driven and compared when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_mc_mem_port;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rdy;
  logic [31:0] mem_rdata;
  logic        halt;

  mc_mem_port #(
    .XLEN    (32),
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdy      (mem_rdy),
    .mem_rdata    (mem_rdata),
    .halt         (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (sys_rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        check("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Called at a negedge with the unit idle; returns at a negedge with it idle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned waits, input logic [31:0] rdata,
                        input logic exp_err, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    exp_t e;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    mem_rdy      = 1'b0;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    e.err   = exp_err;
    e.rdata = exp_err ? 32'd0 : exp_rdata;
    e.cyc   = cyc + 1 + (exp_err ? 0 : waits + 1);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_err) begin
      check("err_no_memreq", 64'(mem_req), 64'd0);
      @(negedge clk);
      check("err_no_memreq2", 64'(mem_req), 64'd0);
      check("err_ready_back", 64'(req_ready), 64'd1);
    end else begin
      for (int unsigned w = 0; w <= waits; w++) begin
        check("mem_req", 64'(mem_req), 64'd1);
        check("mem_we", 64'(mem_we), 64'(we));
        check("mem_addr", 64'(mem_addr), 64'(addr & 32'hFFFF_FFFC));
        check("mem_be", 64'(mem_be), 64'(exp_be));
        check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        mem_rdy   = (w == waits);
        mem_rdata = rdata;
        @(negedge clk);
      end
      mem_rdy = 1'b0;
      check("resp_not_ready", 64'(req_ready), 64'd0);
      check("resp_memreq_off", 64'(mem_req), 64'd0);
      @(negedge clk);
      check("rsp_pulse_end", 64'(rsp_valid), 64'd0);
      check("ready_after_resp", 64'(req_ready), 64'd1);
    end
  endtask

  // Random-stimulus model: byte-wise lane placement and extension
  logic [1:0]  r_size;
  int unsigned r_n;
  int unsigned r_off;
  logic        r_we;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;
  logic [31:0] r_exp_wd;
  logic [31:0] r_exp_rd;
  int unsigned r_waits;

  initial begin
    sys_rst_n    = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_rdy      = 1'b0;
    mem_rdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FF0000, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FF0000, 1'b0, 4'b1000, 32'h0, 32'h00000080);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234, 3, 32'hFFFFFFFF, 1'b0, 4'b1100, 32'h12340000, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1, 32'h80011234, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 2, 32'h80011234, 1'b0, 4'b1100, 32'h0, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 32'h1, 32'hA5, 0, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'h0000A500, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 0, 32'h1234567F, 1'b0, 4'b0001, 32'h0, 32'h0000007F);

    // Random aligned accesses
    for (int k = 0; k < 10; k++) begin
      r_size  = 2'($urandom_range(0, 2));
      r_n     = 1 << r_size;
      r_off   = ($urandom_range(0, 3) / r_n) * r_n;
      r_addr  = ($urandom() & 32'h0000_0FF0) | r_off;
      r_we    = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_wdata = $urandom();
      r_rdata = $urandom();
      r_waits = $urandom_range(0, 3);
      for (int unsigned b = r_n; b < 4; b++) r_wdata[8*b +: 8] = 8'h00;
      r_be     = '0;
      r_exp_wd = '0;
      r_exp_rd = '0;
      for (int unsigned b = 0; b < r_n; b++) begin
        r_be[r_off + b]             = 1'b1;
        r_exp_wd[8*(r_off + b) +: 8] = r_wdata[8*b +: 8];
        r_exp_rd[8*b +: 8]          = r_rdata[8*(r_off + b) +: 8];
      end
      if (!r_uns && r_exp_rd[8*r_n - 1]) begin
        for (int unsigned b = r_n; b < 4; b++) r_exp_rd[8*b +: 8] = 8'hFF;
      end
      if (r_we) r_exp_rd = '0;
      do_req(r_we, r_size, r_uns, r_addr, r_wdata, r_waits, r_rdata, 1'b0, r_be, r_exp_wd, r_exp_rd);
    end

`ifdef MC_MEM_TIMEOUT_EN
    // Timeout: four ACCESS cycles without mem_rdy, error pulse, then dead
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h200;
    mon_e.err    = 1'b1;
    mon_e.rdata  = 32'h0;
    mon_e.cyc    = cyc + 1 + 4;
    sb.push_back(mon_e);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_mem_req", 64'(mem_req), 64'd1);
      @(negedge clk);
    end
    check("to_memreq_drop", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("to_halt", 64'(halt), 64'd1);
    check("to_not_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("dead_no_memreq", 64'(mem_req), 64'd0);
    check("dead_halt_sticky", 64'(halt), 64'd1);
    check("dead_not_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    check("dead_rst_halt", 64'(halt), 64'd0);
    check("dead_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
`else
    // Without the timeout feature a long wait still completes normally
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 20, 32'h55AA55AA, 1'b0, 4'b1111, 32'h0, 32'h55AA55AA);
    check("halt_tied", 64'(halt), 64'd0);
`endif

    // Reset during ACCESS drops the access with no response
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_addr     = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_mem_req", 64'(mem_req), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_mem_req", 64'(mem_req), 64'd0);
    check("mid_rst_mem_be", 64'(mem_be), 64'd0);
    check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    mem_rdy   = 1'b1;
    repeat (3) @(negedge clk);
    mem_rdy = 1'b0;
    check("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);

    // Recovery after reset
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
